// File: rtl/a_format_decode_queue.sv
// Decodes A-form PowerPC instructions (isel and FP arithmetic) into micro-op entries held in a
// first-word-fall-through queue; optional splitting of fused multiply-add into multiply + add.
module a_format_decode_queue #(
  parameter int FIFO_DEPTH              = 4,
  parameter int SPLIT_FMA               = 0,
  parameter int addressWidth            = 64,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [31:0]                        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic [instMinIdWidth-1:0]          numMicroOps_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [1:0]                         op1rw_o,
  output logic [1:0]                         op2rw_o,
  output logic [1:0]                         op3rw_o,
  output logic [1:0]                         op4rw_o,
  output logic                               op1IsReg_o,
  output logic                               op2IsReg_o,
  output logic                               op3IsReg_o,
  output logic                               op4IsReg_o,
  output logic                               modifiesCR_o,
  output logic [19:0]                        instructionBody_o,
  output logic                               illegal_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // rw holds op1 in [7:6] down to op4 in [1:0]; is_reg holds op1 in [3] down to op4 in [0]
  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [funcUnitCodeSize-1:0]        fu;
    logic [instructionCounterWidth-1:0] maj_id;
    logic [instMinIdWidth-1:0]          min_id;
    logic [instMinIdWidth-1:0]          num_uops;
    logic [addressWidth-1:0]            addr;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [7:0]                         rw;
    logic [3:0]                         is_reg;
    logic                               mod_cr;
    logic [19:0]                        body;
  } entry_t;

  typedef enum logic {SEQ_IDLE = 1'b0, SEQ_SECOND = 1'b1} seq_state_e;

  entry_t     mem_q [FIFO_DEPTH];
  entry_t     mem_d [FIFO_DEPTH];
  entry_t     seq_q, seq_d;
  seq_state_e state_q, state_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          illegal_q, illegal_d;

  logic [5:0] prim;
  logic [4:0] xo;
  logic       rc;
  logic       fp_xo_ok, is_fp, is_isel, legal, split;
  entry_t     dec_ent, uop0_ent, uop1_ent, push_ent, head;
  logic       accept, push, pop, not_full;

  // Big-endian bit numbering: primary = bits 0..5, XO = bits 26..30, Rc = bit 31
  always_comb begin
    prim = instruction_i[31:26];
    xo   = instruction_i[5:1];
    rc   = instruction_i[0];
    case (xo)
      5'd18, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25, 5'd26,
      5'd28, 5'd29, 5'd30, 5'd31: fp_xo_ok = 1'b1;
      5'd23:                      fp_xo_ok = (prim == 6'd63);
      default:                    fp_xo_ok = 1'b0;
    endcase
    is_fp   = ((prim == 6'd63) || (prim == 6'd59)) && fp_xo_ok;
    is_isel = (prim == 6'd31) && (xo == 5'd15);
    legal   = is_fp || is_isel;
    split   = (SPLIT_FMA != 0) && is_fp && (xo[4:2] == 3'b111);

    dec_ent.opcode   = opcodeSize'({prim, xo, rc});
    dec_ent.fu       = funcUnitCodeSize'(is_fp);
    dec_ent.maj_id   = instructionMajId_i;
    dec_ent.min_id   = '0;
    dec_ent.num_uops = instMinIdWidth'(1);
    dec_ent.addr     = instructionAddress_i;
    dec_ent.is64     = is64Bit_i;
    dec_ent.pid      = instructionPid_i;
    dec_ent.tid      = instructionTid_i;
    dec_ent.rw       = 8'b01_10_10_10;
    dec_ent.mod_cr   = is_fp && rc;
    dec_ent.body     = instruction_i[25:6];
    if (is_isel) begin
      dec_ent.is_reg = 4'b1110;
    end else begin
      case (xo)
        5'd22, 5'd24, 5'd26: dec_ent.is_reg = 4'b1010;
        5'd18, 5'd20, 5'd21: dec_ent.is_reg = 4'b1110;
        5'd25:               dec_ent.is_reg = 4'b1101;
        default:             dec_ent.is_reg = 4'b1111;
      endcase
    end

    // Multiply half produces the product; the add half accumulates onto it and owns the CR update
    uop0_ent          = dec_ent;
    uop0_ent.num_uops = instMinIdWidth'(2);
    uop0_ent.is_reg   = 4'b1101;
    uop0_ent.mod_cr   = 1'b0;
    uop1_ent          = dec_ent;
    uop1_ent.min_id   = instMinIdWidth'(1);
    uop1_ent.num_uops = instMinIdWidth'(2);
    uop1_ent.rw       = 8'b11_10_10_10;
    uop1_ent.is_reg   = 4'b1010;
  end

  assign not_full = (count_q < CW'(FIFO_DEPTH));
  assign ready_o  = not_full && (state_q == SEQ_IDLE) && !flush_i;
  assign valid_o  = (count_q != '0);
  assign accept   = valid_i && ready_o;
  assign pop      = valid_o && ready_i;

  always_comb begin
    mem_d     = mem_q;
    seq_d     = seq_q;
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    push      = 1'b0;
    push_ent  = dec_ent;
    illegal_d = accept && !legal;

    if (state_q == SEQ_SECOND) begin
      if (not_full) begin
        push     = 1'b1;
        push_ent = seq_q;
        state_d  = SEQ_IDLE;
      end
    end else if (accept && legal) begin
      push = 1'b1;
      if (split) begin
        push_ent = uop0_ent;
        seq_d    = uop1_ent;
        state_d  = SEQ_SECOND;
      end
    end

    if (push) begin
      mem_d[wr_q] = push_ent;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (flush_i) begin
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
      state_d   = SEQ_IDLE;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      seq_q     <= '0;
      state_q   <= SEQ_IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      seq_q     <= seq_d;
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs read zero whenever the queue is empty, including during reset
  assign head = valid_o ? mem_q[rd_q] : '0;

  assign opcode_o             = head.opcode;
  assign functionalUnitType_o = head.fu;
  assign instMajId_o          = head.maj_id;
  assign instMinId_o          = head.min_id;
  assign numMicroOps_o        = head.num_uops;
  assign instructionAddress_o = head.addr;
  assign is64Bit_o            = head.is64;
  assign instPid_o            = head.pid;
  assign instTid_o            = head.tid;
  assign op1rw_o              = head.rw[7:6];
  assign op2rw_o              = head.rw[5:4];
  assign op3rw_o              = head.rw[3:2];
  assign op4rw_o              = head.rw[1:0];
  assign op1IsReg_o           = head.is_reg[3];
  assign op2IsReg_o           = head.is_reg[2];
  assign op3IsReg_o           = head.is_reg[1];
  assign op4IsReg_o           = head.is_reg[0];
  assign modifiesCR_o         = head.mod_cr;
  assign instructionBody_o    = head.body;
  assign illegal_o            = illegal_q;

endmodule

// File: tb/tb_a_format_decode_queue.sv
// Bench for a_format_decode_queue: decode table, full opcode sweep, capacity, FMA split,
// flush/reset corners and a randomized run against a queue-based reference model.
module tb_a_format_decode_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, is64;
  logic [31:0] instr;
  logic [63:0] addr, maj;
  logic [19:0] pid;
  logic [15:0] tid;
  logic        vld_a, rdyi_a, vld_b, rdyi_b;

  wire        rdyo_a, vldo_a, is64o_a, mcr_a, ill_a;
  wire [11:0] opc_a;
  wire [2:0]  fu_a;
  wire [63:0] majo_a, addro_a;
  wire [6:0]  mino_a, nuo_a;
  wire [19:0] pido_a, body_a;
  wire [15:0] tido_a;
  wire [7:0]  rw_a;
  wire [3:0]  ir_a;

  wire        rdyo_b, vldo_b, is64o_b, mcr_b, ill_b;
  wire [11:0] opc_b;
  wire [2:0]  fu_b;
  wire [63:0] majo_b, addro_b;
  wire [6:0]  mino_b, nuo_b;
  wire [19:0] pido_b, body_b;
  wire [15:0] tido_b;
  wire [7:0]  rw_b;
  wire [3:0]  ir_b;

  a_format_decode_queue dut_a (
    .clock_i(clk), .reset_i(rst_n), .flush_i(flush), .valid_i(vld_a), .ready_o(rdyo_a),
    .instruction_i(instr), .instructionAddress_i(addr), .is64Bit_i(is64),
    .instructionPid_i(pid), .instructionTid_i(tid), .instructionMajId_i(maj),
    .valid_o(vldo_a), .ready_i(rdyi_a), .opcode_o(opc_a), .functionalUnitType_o(fu_a),
    .instMajId_o(majo_a), .instMinId_o(mino_a), .numMicroOps_o(nuo_a),
    .instructionAddress_o(addro_a), .is64Bit_o(is64o_a), .instPid_o(pido_a), .instTid_o(tido_a),
    .op1rw_o(rw_a[7:6]), .op2rw_o(rw_a[5:4]), .op3rw_o(rw_a[3:2]), .op4rw_o(rw_a[1:0]),
    .op1IsReg_o(ir_a[3]), .op2IsReg_o(ir_a[2]), .op3IsReg_o(ir_a[1]), .op4IsReg_o(ir_a[0]),
    .modifiesCR_o(mcr_a), .instructionBody_o(body_a), .illegal_o(ill_a)
  );

  a_format_decode_queue #(.SPLIT_FMA(1)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .flush_i(flush), .valid_i(vld_b), .ready_o(rdyo_b),
    .instruction_i(instr), .instructionAddress_i(addr), .is64Bit_i(is64),
    .instructionPid_i(pid), .instructionTid_i(tid), .instructionMajId_i(maj),
    .valid_o(vldo_b), .ready_i(rdyi_b), .opcode_o(opc_b), .functionalUnitType_o(fu_b),
    .instMajId_o(majo_b), .instMinId_o(mino_b), .numMicroOps_o(nuo_b),
    .instructionAddress_o(addro_b), .is64Bit_o(is64o_b), .instPid_o(pido_b), .instTid_o(tido_b),
    .op1rw_o(rw_b[7:6]), .op2rw_o(rw_b[5:4]), .op3rw_o(rw_b[3:2]), .op4rw_o(rw_b[1:0]),
    .op1IsReg_o(ir_b[3]), .op2IsReg_o(ir_b[2]), .op3IsReg_o(ir_b[1]), .op4IsReg_o(ir_b[0]),
    .modifiesCR_o(mcr_b), .instructionBody_o(body_b), .illegal_o(ill_b)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] w;
    logic [63:0] addr;
    logic [63:0] maj;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
  } txn_t;

  typedef struct {
    int         p;
    int         xo;
    bit         rc;
    bit         legal;
    bit         fp;
    logic [3:0] isreg;
    bit         mcr;
  } vec_t;

  txn_t mq[$];
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int p, input int xo, input bit rc);
    return {6'(p), 5'd14, 5'd21, 5'd10, 5'd17, 5'(xo), rc};
  endfunction

  // Reference decode straight from the legal-encoding list and operand-class rules
  function automatic void ref_dec(input logic [31:0] w, output bit legal, output bit fp,
                                  output logic [3:0] isreg, output bit mcr);
    int p, x;
    int fpx [12];
    bit in_fp;
    p = int'(w[31:26]);
    x = int'(w[5:1]);
    fpx = '{18, 20, 21, 22, 23, 24, 25, 26, 28, 29, 30, 31};
    in_fp = 1'b0;
    foreach (fpx[i]) if (fpx[i] == x) in_fp = 1'b1;
    fp = ((p == 63) && in_fp) || ((p == 59) && in_fp && (x != 23));
    legal = fp || ((p == 31) && (x == 15));
    mcr = fp && w[0];
    if (!fp) isreg = 4'b1110;
    else if (x == 22 || x == 24 || x == 26) isreg = 4'b1010;
    else if (x == 25) isreg = 4'b1101;
    else if (x >= 18 && x <= 21) isreg = 4'b1110;
    else isreg = 4'b1111;
  endfunction

  task automatic drive(input logic [31:0] w, input logic [63:0] m);
    instr = w;
    maj   = m;
    addr  = (m << 3) + 64'h4000;
    pid   = 20'(m + 3);
    tid   = 16'(m ^ 64'h5);
    is64  = m[0];
  endtask

  function automatic txn_t cur_txn();
    txn_t t;
    t.w = instr; t.addr = addr; t.maj = maj; t.is64 = is64; t.pid = pid; t.tid = tid;
    return t;
  endfunction

  task automatic chk_side_a(input txn_t t);
    chk("a.opcode", 64'(opc_a), 64'({t.w[31:26], t.w[5:1], t.w[0]}));
    chk("a.majid", majo_a, t.maj);
    chk("a.addr", addro_a, t.addr);
    chk("a.pid", 64'(pido_a), 64'(t.pid));
    chk("a.tid", 64'(tido_a), 64'(t.tid));
    chk("a.is64", 64'(is64o_a), 64'(t.is64));
    chk("a.minid", 64'(mino_a), 64'd0);
    chk("a.numuops", 64'(nuo_a), 64'd1);
    chk("a.rw", 64'(rw_a), 64'h6A);
    chk("a.body", 64'(body_a), 64'(t.w[25:6]));
  endtask

  task automatic chk_front_a(input txn_t t);
    bit lg, fp, mc;
    logic [3:0] ir;
    ref_dec(t.w, lg, fp, ir, mc);
    chk_side_a(t);
    chk("a.fu", 64'(fu_a), 64'(fp));
    chk("a.isreg", 64'(ir_a), 64'(ir));
    chk("a.modcr", 64'(mcr_a), 64'(mc));
  endtask

  task automatic fill_b();
    rdyi_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(63, 21, 0), 64'(200 + i));
      vld_b = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    drive(mk(59, 28, 1), 64'd210);
    @(posedge clk); @(negedge clk);
    vld_b = 1'b0;
    #1;
    chk("fill.ready_low", 64'(rdyo_b), 64'd0);
    chk("fill.valid", 64'(vldo_b), 64'd1);
  endtask

  task automatic drain_b_expect_none(input string nm);
    int beats = 0;
    rdyi_b = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (vldo_b) beats++;
    end
    chk(nm, 64'(beats), 64'd0);
  endtask

  initial begin
    int beats, pulses, lows, k, got, cyc;
    bit acc, mr, pop, lg, fp, mc;
    logic [3:0] ir;
    txn_t t;
    logic [5:0] prims [3];

    tbl[0]  = '{63, 21, 0, 1, 1, 4'b1110, 0};
    tbl[1]  = '{63, 21, 1, 1, 1, 4'b1110, 1};
    tbl[2]  = '{31, 15, 0, 1, 0, 4'b1110, 0};
    tbl[3]  = '{31, 15, 1, 1, 0, 4'b1110, 0};
    tbl[4]  = '{63, 25, 0, 1, 1, 4'b1101, 0};
    tbl[5]  = '{63, 22, 0, 1, 1, 4'b1010, 0};
    tbl[6]  = '{59, 24, 1, 1, 1, 4'b1010, 1};
    tbl[7]  = '{63, 26, 0, 1, 1, 4'b1010, 0};
    tbl[8]  = '{63, 23, 0, 1, 1, 4'b1111, 0};
    tbl[9]  = '{59, 23, 0, 0, 0, 4'b0000, 0};
    tbl[10] = '{63, 29, 0, 1, 1, 4'b1111, 0};
    tbl[11] = '{59, 18, 0, 1, 1, 4'b1110, 0};
    tbl[12] = '{31, 16, 0, 0, 0, 4'b0000, 0};
    tbl[13] = '{63, 19, 0, 0, 0, 4'b0000, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 4'b0000, 0};
    tbl[15] = '{59, 31, 1, 1, 1, 4'b1111, 1};
    prims = '{6'd31, 6'd59, 6'd63};

    rst_n = 1'b0; flush = 1'b0; vld_a = 1'b0; vld_b = 1'b0; rdyi_a = 1'b0; rdyi_b = 1'b0;
    drive(32'h0, 64'd0);
    #1;
    chk("rst.valid_a", 64'(vldo_a), 64'd0);
    chk("rst.illegal_a", 64'(ill_a), 64'd0);
    chk("rst.opcode_a", 64'(opc_a), 64'd0);
    chk("rst.majid_a", majo_a, 64'd0);
    chk("rst.valid_b", 64'(vldo_b), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Decode table, one instruction per cycle, ready_i held high
    rdyi_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(mk(tbl[i].p, tbl[i].xo, tbl[i].rc), 64'(1000 + i));
      vld_a = 1'b1;
      t = cur_txn();
      #1;
      chk("tbl.ready", 64'(rdyo_a), 64'd1);
      @(posedge clk); @(negedge clk);
      chk("tbl.valid", 64'(vldo_a), 64'(tbl[i].legal));
      chk("tbl.illegal", 64'(ill_a), 64'(!tbl[i].legal));
      if (tbl[i].legal) begin
        chk_side_a(t);
        chk("tbl.fu", 64'(fu_a), 64'(tbl[i].fp));
        chk("tbl.isreg", 64'(ir_a), 64'(tbl[i].isreg));
        chk("tbl.modcr", 64'(mcr_a), 64'(tbl[i].mcr));
      end
    end
    vld_a = 1'b0;
    @(negedge clk);
    chk("tbl.drained", 64'(vldo_a), 64'd0);
    chk("tbl.illegal_clear", 64'(ill_a), 64'd0);

    // Sweep every primary x XO with fixed operands
    beats = 0; pulses = 0; lows = 0;
    for (int p = 0; p < 64; p++) begin
      for (int x = 0; x < 32; x++) begin
        drive(mk(p, x, 0), 64'(p * 32 + x));
        vld_a = 1'b1;
        #1;
        if (!rdyo_a) lows++;
        @(negedge clk);
        if (vldo_a) beats++;
        if (ill_a) pulses++;
      end
    end
    vld_a = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (vldo_a) beats++;
      if (ill_a) pulses++;
    end
    chk("sweep.beats", 64'(beats), 64'd24);
    chk("sweep.illegal", 64'(pulses), 64'd2024);
    chk("sweep.ready_lows", 64'(lows), 64'd0);

    // Capacity: six pushes against a stalled output
    rdyi_a = 1'b0; k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(mk(63, 21, 0), 64'(100 + k));
      vld_a = 1'b1;
      #1;
      acc = rdyo_a;
      chk("cap.ready", 64'(rdyo_a), 64'(k < 4));
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    chk("cap.accepted", 64'(k), 64'd4);
    rdyi_a = 1'b1; got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      if (vldo_a) begin
        chk("cap.order", majo_a, 64'(100 + got));
        got++;
      end
      if (k < 6) begin
        drive(mk(63, 21, 0), 64'(100 + k));
        vld_a = 1'b1;
      end else begin
        vld_a = 1'b0;
      end
      #1;
      acc = rdyo_a && vld_a;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
      cyc++;
    end
    vld_a = 1'b0;
    chk("cap.beats", 64'(got), 64'd6);

    // FMA split on the second instance
    @(negedge clk);
    rdyi_b = 1'b1;
    drive(mk(63, 29, 0), 64'd77);
    vld_b = 1'b1;
    #1;
    chk("fma.ready_in", 64'(rdyo_b), 64'd1);
    @(posedge clk); @(negedge clk);
    vld_b = 1'b0;
    lows = 0;
    #1;
    if (!rdyo_b) lows++;
    chk("fma.u0.valid", 64'(vldo_b), 64'd1);
    chk("fma.u0.minid", 64'(mino_b), 64'd0);
    chk("fma.u0.numuops", 64'(nuo_b), 64'd2);
    chk("fma.u0.isreg", 64'(ir_b), 64'hD);
    chk("fma.u0.rw1", 64'(rw_b[7:6]), 64'd1);
    chk("fma.u0.majid", majo_b, 64'd77);
    @(posedge clk); @(negedge clk);
    #1;
    if (!rdyo_b) lows++;
    chk("fma.u1.valid", 64'(vldo_b), 64'd1);
    chk("fma.u1.minid", 64'(mino_b), 64'd1);
    chk("fma.u1.numuops", 64'(nuo_b), 64'd2);
    chk("fma.u1.rw1", 64'(rw_b[7:6]), 64'd3);
    chk("fma.u1.op3reg", 64'(ir_b[1]), 64'd1);
    chk("fma.u1.majid", majo_b, 64'd77);
    chk("fma.u1.opcode", 64'(opc_b), 64'({6'd63, 5'd29, 1'b0}));
    @(posedge clk); @(negedge clk);
    #1;
    if (!rdyo_b) lows++;
    chk("fma.done", 64'(vldo_b), 64'd0);
    chk("fma.ready_lows", 64'(lows), 64'd1);

    // Flush while full and holding a pending second micro-op
    @(negedge clk);
    fill_b();
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("flush.valid", 64'(vldo_b), 64'd0);
    chk("flush.illegal", 64'(ill_b), 64'd0);
    flush = 1'b0;
    drain_b_expect_none("flush.no_uop1");
    #1;
    chk("flush.ready_idle", 64'(rdyo_b), 64'd1);

    // Asynchronous reset mid-cycle under the same conditions
    @(negedge clk);
    fill_b();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(vldo_b), 64'd0);
    chk("arst.minid", 64'(mino_b), 64'd0);
    chk("arst.numuops", 64'(nuo_b), 64'd0);
    chk("arst.illegal", 64'(ill_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drain_b_expect_none("arst.no_uop1");

    // Randomized traffic against the queue model
    mq.delete();
    pulses = 0;
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      chk("rnd.valid", 64'(vldo_a), 64'(mq.size() > 0));
      if (mq.size() > 0) chk_front_a(mq[0]);
      chk("rnd.illegal", 64'(ill_a), 64'(pulses));
      flush  = ($urandom_range(0, 39) == 0);
      vld_a  = ($urandom_range(0, 3) != 0);
      rdyi_a = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0)
        instr = {prims[$urandom_range(0, 2)], 20'($urandom), 5'($urandom_range(14, 31)), 1'($urandom)};
      else
        instr = $urandom;
      addr = {$urandom, $urandom}; maj = {$urandom, $urandom};
      pid = 20'($urandom); tid = 16'($urandom); is64 = 1'($urandom);
      t = cur_txn();
      #1;
      mr  = (mq.size() < 4) && !flush;
      chk("rnd.ready", 64'(rdyo_a), 64'(mr));
      acc = vld_a && mr;
      pop = (mq.size() > 0) && rdyi_a;
      @(posedge clk);
      if (flush) begin
        mq.delete();
        pulses = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        ref_dec(t.w, lg, fp, ir, mc);
        if (acc && lg) mq.push_back(t);
        pulses = (acc && !lg) ? 1 : 0;
      end
      @(negedge clk);
    end
    flush = 1'b0; vld_a = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/a_format_decode_queue.md
A_FORMAT_DECODE_QUEUE -- requirements
Module: a_format_decode_queue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output queue entries (power of two, >=2).
REQ-002 SHALL have parameter SPLIT_FMA, default 0, 1 = split fused multiply-add into two micro-ops.
REQ-003 SHALL have parameters addressWidth 64, PidSize 20, TidSize 16, instructionCounterWidth 64, instMinIdWidth 7, opcodeSize 12, funcUnitCodeSize 3, with the usual meanings.
REQ-004 SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-005 Ports: clock_i in 1, the clock.
REQ-006 Ports: reset_i in 1, asynchronous active-low reset.
REQ-007 Ports: flush_i in 1, discard queue and sequencer.
REQ-008 Ports: valid_i in 1 and ready_o out 1, input handshake.
REQ-009 Ports: instruction_i in 32; instructionAddress_i in 64; is64Bit_i in 1; instructionPid_i in 20; instructionTid_i in 16; instructionMajId_i in 64.
REQ-010 Ports: valid_o out 1 and ready_i in 1, output handshake.
REQ-011 Ports: opcode_o out 12; functionalUnitType_o out 3; instMajId_o out 64; instMinId_o out 7; numMicroOps_o out 7; instructionAddress_o out 64; is64Bit_o out 1; instPid_o out 20; instTid_o out 16.
REQ-012 Ports: op1rw_o..op4rw_o out 2 each; op1IsReg_o..op4IsReg_o out 1 each; modifiesCR_o out 1; instructionBody_o out 20; illegal_o out 1.

Function
REQ-013 Input transfer on a rising edge with valid_i & ready_o; output transfer with valid_o & ready_i.
REQ-014 ready_o = (entries < FIFO_DEPTH) & sequencer IDLE & !flush_i; combinational, no dependence on ready_i.
REQ-015 Legal set is exactly 24 encodings:
- primary 31, XO[26:30]=15 (isel)
- primary 63, XO 18,20-26,28-31 (12)
- primary 59, XO 18,20,21,22,24,25,26,28-31 (11)
REQ-016 Accepted illegal word: not enqueued; illegal_o = 1 for exactly the following cycle; otherwise illegal_o = 0.
REQ-017 opcode_o = {primary[0:5], XO[0:4], Rc}; instructionBody_o = instruction bits 6..25.
REQ-018 functionalUnitType_o: FP (1) for primaries 59/63, FX (0) for isel.
REQ-019 op1 is write (2'b01), op2-op4 are read (2'b10).
REQ-020 IsReg flags for FP:
- fsqrt/fre/frsqrte/fres: only op1, op3 set
- fadd/fsub/fdiv: op1-op3 set
- fmul: op1, op2, op4 set
- all others: all four set
REQ-021 IsReg flags for isel: op1-op3 set, op4 clear (BC field).
REQ-022 modifiesCR_o = Rc for FP; 0 for isel.
REQ-023 Non-split instructions: instMinId_o = 0, numMicroOps_o = 1.
REQ-024 Latency: an entry accepted at edge N is visible on valid_o after edge N (one cycle), first-word-fall-through.
REQ-025 Sequencer states IDLE and SECOND.
- When SPLIT_FMA=1, an accepted fmadd/fmsub/fnmadd/fnmsub (59 or 63) enqueues uop0 (minId 0, numMicroOps 2, multiply: op1 write, op2/op4 read, op3 IsReg 0) and enters SECOND.
- In SECOND, uop1 (minId 1, numMicroOps 2, add/sub: op1 read-write 2'b11, op3 read) is enqueued once an entry is free, then the sequencer returns to IDLE.
- ready_o = 0 throughout SECOND.
REQ-026 Both micro-ops carry the same instMajId_o, address, Pid, Tid and is64Bit.
REQ-027 Simultaneous push and pop SHALL be allowed at any occupancy below full; entry count unchanged.
- When full, push is blocked by ready_o.
- Pop from an empty queue is impossible (valid_o = 0).
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH with no gap or duplicate.
REQ-029 flush_i SHALL take priority over push, pop and sequencer: next edge gives entries = 0, IDLE, illegal_o = 0.

Reset
REQ-030 reset_i low SHALL immediately force entries = 0, IDLE, valid_o = 0, illegal_o = 0, all other outputs 0, with no clock required; a pending uop1 is discarded.
REQ-031 First input transfer is possible on the first rising edge after reset_i rises.

Verification
REQ-032 Sweep of all 64 primaries x 32 XO, operands 14/21/10/17, ready_i = 1 -> exactly 24 valid_o beats, 2024 illegal_o pulses.
REQ-033 0xFC22182A (fadd) -> valid_o next cycle; opcode_o = {63,21,0}; unit 1; op4IsReg_o 0; numMicroOps_o 1.
REQ-034 SPLIT_FMA = 1, 0xFC22193A (fmadd) -> two beats, minId 0 then 1, both numMicroOps 2, equal MajId; ready_o low for 1 cycle.
REQ-035 ready_i = 0 with 6 legal pushes, FIFO_DEPTH 4 -> ready_o low after 4; release gives 4 beats in order, then the remaining 2.
REQ-036 flush_i or reset_i low while full and in SECOND -> valid_o = 0 next cycle (reset: immediately); uop1 never emitted.
